lcd_write_sequencer: RTL and testbench
======================================

// Module: lcd_write_sequencer
// PURPOSE
//  Sequences one HD44780 bus write per request: drives RS/DB, generates the E strobe with
//  setup/pulse/hold timing, then waits out the command execution time before accepting more.
//  Owns a single internal down-counter that serves every timing phase.
//  Sits between the command/init FSMs (requesters) and the LCD pins.
//  Supports 8-bit and 4-bit bus modes.
// PARAMETERS
//  FOUR_BIT  0      1 = 4-bit bus (DB[7:4] only, two nibbles per byte); 0 = 8-bit bus
//  TSU       2      cycles RS/DB are stable with E low before E rises (>=1)
//  TPW       12     cycles E is held high (>=1)
//  THOLD     2      cycles RS/DB are held with E low after E falls (>=1)
//  TEXEC     1850   execution wait after the last strobe, normal commands/data (>=1)
//  TCLR      76000  execution wait for Clear Display/Return Home (>=TEXEC)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-high
//  req_valid    in   1  request present
//  req_ready    out  1  high when the sequencer can accept a request (state IDLE)
//  req_rs       in   1  RS value for this write (0 = instruction, 1 = data)
//  req_data     in   8  byte to write
//  req_nibble   in   1  FOUR_BIT=1 only: send the high nibble only (init-time writes); ignored if FOUR_BIT=0
//  lcd_rs       out  1  LCD RS pin
//  lcd_rw       out  1  LCD R/W pin; constant 0 (write-only)
//  lcd_e        out  1  LCD E strobe
//  lcd_db       out  8  LCD data bus; FOUR_BIT=1 drives the nibble on [7:4], [3:0] = 0
//  done         out  1  one-cycle pulse when a request has fully completed
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, counter 0; lcd_e=0, lcd_rs=0, lcd_db=0, done=0, req_ready=1.
//  - Accept: req_valid & req_ready sampled at edge A; req_rs, req_data, req_nibble captured; later input changes ignored.
//  - req_valid while not IDLE: ignored, no queuing.
//  - States: IDLE -> SETUP -> E_HIGH -> HOLD -> [SETUP (2nd nibble)] -> EXEC_WAIT -> IDLE.
//  - Counter: loaded with (phase length - 1) on phase entry; the phase ends on the edge where it reads 0.
//  - Counter width: $clog2(TCLR).
//  - Phase lengths: SETUP = TSU, E_HIGH = TPW, HOLD = THOLD cycles.
//  - lcd_e = 1 only in E_HIGH. lcd_rs/lcd_db are registered and stable from SETUP through HOLD.
//  - lcd_rs/lcd_db keep their last value in EXEC_WAIT and IDLE.
//  - 4-bit mode: first strobe sends data[7:4]; unless req_nibble, HOLD loops to SETUP with data[3:0] for a second strobe.
//  - EXEC_WAIT length = TCLR if req_rs=0 && data[7:2]==0 && data!=0 (0x01..0x03); otherwise TEXEC.
//  - Completion: on the last EXEC_WAIT edge, go to IDLE with done=1 for exactly that IDLE cycle.
//    req_ready is also 1 in that cycle, so back-to-back accepts are allowed (no dead cycle).
//  - Latency: let S = TSU+TPW+THOLD and nstrobe = 1 or 2. Then:
//    E first rises at edge A+TSU; done is high in the cycle starting at edge A + nstrobe*S + EXEC.
//  - Reset mid-operation: the write is abandoned; E drops asynchronously; no done pulse.
// TESTING
//  - Reset during E_HIGH -> lcd_e drops to 0 with no clk edge; after release: req_ready=1, done stays 0.
//  - 8-bit, default params, rs=1 data=0x41 accepted at edge 0 -> lcd_db=0x41, lcd_rs=1 from edge 0.
//    lcd_e high for edges 2..13 (12 cycles); done is a single pulse at edge 1866.
//  - FOUR_BIT=1, rs=0 data=0x28 -> strobe 1: db[7:4]=0x2 (E at edges 2..13);
//    strobe 2: db[7:4]=0x8 (E at edges 18..29); db[3:0]=0; done at edge 1882.
//  - 8-bit, rs=0 data=0x01 -> done at edge 76016.
//    rs=1 data=0x01 -> done at edge 1866 (data write, normal TEXEC wait).
//  - FOUR_BIT=1, req_nibble=1, data=0x30 -> exactly one E pulse with db[7:4]=0x3; done at edge 1866.
//  - req_valid held high with two queued bytes -> second accept in the done cycle; E pulses never overlap.
//    A toggle of req_data while busy has no effect on lcd_db.

Source files
------------

// File: rtl/lcd_write_sequencer_if.sv
// Requester-side handshake plus LCD pin bundle for the HD44780 write sequencer.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_rs/req_data/req_nibble are sampled on that
// edge only. req_ready is high only while the sequencer is idle, and a
// requester may hold req_valid high across busy cycles (it is not queued).
interface lcd_write_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_nibble;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       done;
  logic [2:0] dbg_state;

  // Requester (command/init FSMs, or a bench)
  modport master (
    output req_valid, req_rs, req_data, req_nibble,
    input  req_ready, lcd_rs, lcd_rw, lcd_e, lcd_db, done, dbg_state
  );

  // The sequencer itself
  modport slave (
    input  req_valid, req_rs, req_data, req_nibble,
    output req_ready, lcd_rs, lcd_rw, lcd_e, lcd_db, done, dbg_state
  );
endinterface

// File: rtl/lcd_write_sequencer.sv
// One HD44780 bus write per request: RS/DB setup, E pulse, hold, optional
// second nibble in 4-bit mode, then the command execution wait. A single
// down-counter times every phase; it is loaded with (length - 1) on phase
// entry and the phase ends on the edge where it reads zero.
module lcd_write_sequencer #(
  parameter bit          FOUR_BIT = 1'b0,
  parameter int unsigned TSU      = 2,
  parameter int unsigned TPW      = 12,
  parameter int unsigned THOLD    = 2,
  parameter int unsigned TEXEC    = 1850,
  parameter int unsigned TCLR     = 76000
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_write_sequencer_if.slave  bus
);

  localparam int CW = (TCLR > 1) ? $clog2(TCLR) : 1;

  localparam logic [CW-1:0] TSU_M1   = CW'(TSU - 1);
  localparam logic [CW-1:0] TPW_M1   = CW'(TPW - 1);
  localparam logic [CW-1:0] THOLD_M1 = CW'(THOLD - 1);
  localparam logic [CW-1:0] TEXEC_M1 = CW'(TEXEC - 1);
  localparam logic [CW-1:0] TCLR_M1  = CW'(TCLR - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_E_HIGH    = 3'd2,
    S_HOLD      = 3'd3,
    S_EXEC_WAIT = 3'd4
  } state_t;

  state_t        state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [3:0]    lo_q,     lo_d;      // low nibble kept for the second strobe
  logic          nibble_q, nibble_d;  // single-strobe request (4-bit mode only)
  logic          second_q, second_d;  // currently sending the second nibble
  logic          long_q,   long_d;    // Clear Display / Return Home wait
  logic          lcd_e_q,  lcd_e_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic [7:0]    lcd_db_q, lcd_db_d;
  logic          done_q,   done_d;

  // Next-state and next-output computation for the whole write sequence
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    nibble_d = nibble_q;
    second_d = second_q;
    long_d   = long_q;
    lcd_e_d  = lcd_e_q;
    lcd_rs_d = lcd_rs_q;
    lcd_db_d = lcd_db_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d  = S_SETUP;
          cnt_d    = TSU_M1;
          lo_d     = bus.req_data[3:0];
          nibble_d = FOUR_BIT & bus.req_nibble;
          second_d = 1'b0;
          // 0x01..0x03 as an instruction: Clear Display / Return Home
          long_d   = ~bus.req_rs && (bus.req_data[7:2] == 6'd0) && (bus.req_data != 8'd0);
          lcd_rs_d = bus.req_rs;
          lcd_db_d = FOUR_BIT ? {bus.req_data[7:4], 4'b0000} : bus.req_data;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_E_HIGH;
          cnt_d   = TPW_M1;
          lcd_e_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_E_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = THOLD_M1;
          lcd_e_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (FOUR_BIT && !second_q && !nibble_q) begin
            state_d  = S_SETUP;
            cnt_d    = TSU_M1;
            second_d = 1'b1;
            lcd_db_d = {lo_q, 4'b0000};
          end else begin
            state_d = S_EXEC_WAIT;
            cnt_d   = long_q ? TCLR_M1 : TEXEC_M1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EXEC_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        lcd_e_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered pin outputs; reset drops E immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lo_q     <= 4'd0;
      nibble_q <= 1'b0;
      second_q <= 1'b0;
      long_q   <= 1'b0;
      lcd_e_q  <= 1'b0;
      lcd_rs_q <= 1'b0;
      lcd_db_q <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      nibble_q <= nibble_d;
      second_q <= second_d;
      long_q   <= long_d;
      lcd_e_q  <= lcd_e_d;
      lcd_rs_q <= lcd_rs_d;
      lcd_db_q <= lcd_db_d;
      done_q   <= done_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.lcd_rs    = lcd_rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_e     = lcd_e_q;
  assign bus.lcd_db    = lcd_db_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with default timing parameters.
// u8/u4 are 8-bit and 4-bit instances; uc is an 8-bit instance dedicated to
// the long Clear Display wait, which runs concurrently with the other tests.
module tb_lcd_write_sequencer;

  logic clk;
  logic rst_m;
  logic rst_c;

  int checks   = 0;
  int failures = 0;

  lcd_write_sequencer_if bus8();
  lcd_write_sequencer_if bus4();
  lcd_write_sequencer_if busc();

  lcd_write_sequencer #(.FOUR_BIT(1'b0)) u8 (.clk(clk), .rst(rst_m), .bus(bus8));
  lcd_write_sequencer #(.FOUR_BIT(1'b1)) u4 (.clk(clk), .rst(rst_m), .bus(bus4));
  lcd_write_sequencer #(.FOUR_BIT(1'b0)) uc (.clk(clk), .rst(rst_c), .bus(busc));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic       done;
    logic       ready;
    logic [7:0] db;
  } snap_t;

  typedef struct {
    int         dut;      // 0 = u8, 1 = u4
    logic       rs;
    logic [7:0] data;
    logic       nib;
    int         strobes;
    logic [7:0] db1;
    logic [7:0] db2;
    int         done_at;  // cycle index (from accept edge) where done is high
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic rs, input logic [7:0] data, input logic nib);
    if (d == 0) begin
      bus8.req_valid = v; bus8.req_rs = rs; bus8.req_data = data; bus8.req_nibble = nib;
    end else begin
      bus4.req_valid = v; bus4.req_rs = rs; bus4.req_data = data; bus4.req_nibble = nib;
    end
  endtask

  function automatic snap_t snap(input int d);
    snap_t s;
    if (d == 0) s = '{bus8.lcd_e, bus8.lcd_rs, bus8.lcd_rw, bus8.done, bus8.req_ready, bus8.lcd_db};
    else        s = '{bus4.lcd_e, bus4.lcd_rs, bus4.lcd_rw, bus4.done, bus4.req_ready, bus4.lcd_db};
    return s;
  endfunction

  // ---------------- driver: one write, traced cycle by cycle ----------------
  task automatic run_vec(input int idx, input vec_t v);
    snap_t      s;
    int         rise_at[4];
    int         width[4];
    logic [7:0] db_at[4];
    logic       rs_at[4];
    int         nrise  = 0;
    int         ndone  = 0;
    int         done_k = -1;
    logic       prev_e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rise_at[i] = -1; width[i] = 0; db_at[i] = 8'h00; rs_at[i] = 1'b0;
    end

    @(negedge clk);
    s = snap(v.dut);
    check($sformatf("v%0d ready_before", idx), s.ready, 1);
    drive(v.dut, 1'b1, v.rs, v.data, v.nib);
    @(negedge clk);  // cycle A+0
    drive(v.dut, 1'b0, ~v.rs, ~v.data, ~v.nib);
    for (int k = 0; k <= v.done_at + 3; k++) begin
      if (k > 0) @(negedge clk);
      s = snap(v.dut);
      if (k == 0) begin
        check($sformatf("v%0d ready_busy", idx), s.ready, 0);
        check($sformatf("v%0d db_at_accept", idx), s.db, v.db1);
        check($sformatf("v%0d rs_at_accept", idx), s.rs, v.rs);
      end
      if (s.e && !prev_e) begin
        if (nrise < 4) begin
          rise_at[nrise] = k; db_at[nrise] = s.db; rs_at[nrise] = s.rs;
        end
        nrise++;
      end
      if (s.e && nrise >= 1 && nrise <= 4) width[nrise-1]++;
      if (s.done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      prev_e = s.e;
    end
    check($sformatf("v%0d strobes", idx), nrise, v.strobes);
    check($sformatf("v%0d rise1", idx), rise_at[0], 2);
    check($sformatf("v%0d width1", idx), width[0], 12);
    check($sformatf("v%0d db1", idx), db_at[0], v.db1);
    check($sformatf("v%0d rs1", idx), rs_at[0], v.rs);
    if (v.strobes == 2) begin
      check($sformatf("v%0d rise2", idx), rise_at[1], 18);
      check($sformatf("v%0d width2", idx), width[1], 12);
      check($sformatf("v%0d db2", idx), db_at[1], v.db2);
    end
    check($sformatf("v%0d done_at", idx), done_k, v.done_at);
    check($sformatf("v%0d done_pulses", idx), ndone, 1);
    check($sformatf("v%0d db_held", idx), s.db, (v.strobes == 2) ? v.db2 : v.db1);
    check($sformatf("v%0d rw", idx), s.rw, 0);
    check($sformatf("v%0d ready_after", idx), s.ready, 1);
  endtask

  // ---------------- hand-written sequences ----------------
  // Two bytes with req_valid held high: second accept lands in the done cycle.
  task automatic back_to_back();
    snap_t      s;
    int         rises[$];
    int         dones[$];
    logic [7:0] dbs[$];
    int         ehigh  = 0;
    logic       prev_e = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h41, 1'b0);
    @(negedge clk);  // cycle A+0: present the next byte immediately
    drive(0, 1'b1, 1'b1, 8'h42, 1'b0);
    for (int k = 0; k <= 3736; k++) begin
      if (k > 0) @(negedge clk);
      s = snap(0);
      if (k == 1) check("b2b db_ignores_toggle", s.db, 8'h41);
      if (k == 1866) check("b2b ready_in_done", {s.done, s.ready}, 2'b11);
      if (k == 1867) begin
        check("b2b second_accepted", s.ready, 0);
        check("b2b db_second", s.db, 8'h42);
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
      end
      if (s.e && !prev_e) begin rises.push_back(k); dbs.push_back(s.db); end
      if (s.e) ehigh++;
      if (s.done) dones.push_back(k);
      prev_e = s.e;
    end
    check("b2b n_rises", rises.size(), 2);
    check("b2b n_dones", dones.size(), 2);
    check("b2b e_cycles", ehigh, 24);
    if (rises.size() == 2) begin
      check("b2b rise_a", rises[0], 2);
      check("b2b rise_b", rises[1], 1869);
      check("b2b db_a", dbs[0], 8'h41);
      check("b2b db_b", dbs[1], 8'h42);
    end
    if (dones.size() == 2) begin
      check("b2b done_a", dones[0], 1866);
      check("b2b done_b", dones[1], 3733);
    end
  endtask

  // Reset asserted while E is high on the 4-bit instance.
  task automatic reset_mid_pulse();
    snap_t s;
    int    bad_done  = 0;
    int    bad_e     = 0;
    int    bad_ready = 0;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 8'hA5, 1'b0);
    @(negedge clk);  // cycle A+0
    drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (5) @(negedge clk);  // cycle A+5, inside the first E pulse
    s = snap(1);
    check("rstmid e_before", s.e, 1);
    #1 rst_m = 1'b1;
    #1 s = snap(1);
    check("rstmid e_async", s.e, 0);
    check("rstmid ready", s.ready, 1);
    check("rstmid db_cleared", s.db, 8'h00);
    @(negedge clk);
    rst_m = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      s = snap(1);
      if (s.done)   bad_done++;
      if (s.e)      bad_e++;
      if (!s.ready) bad_ready++;
    end
    check("rstmid no_done", bad_done, 0);
    check("rstmid no_e", bad_e, 0);
    check("rstmid ready_stays", bad_ready, 0);
  endtask

  // Clear Display on the dedicated instance: the long execution wait.
  task automatic clear_display();
    int   rise_k = -1;
    int   nrise  = 0;
    int   done_k = -1;
    int   ndone  = 0;
    logic prev_e = 1'b0;
    @(negedge clk);
    busc.req_valid = 1'b1; busc.req_rs = 1'b0; busc.req_data = 8'h01; busc.req_nibble = 1'b0;
    @(negedge clk);  // cycle A+0
    busc.req_valid = 1'b0;
    for (int k = 0; k <= 76018; k++) begin
      if (k > 0) @(negedge clk);
      if (busc.lcd_e && !prev_e) begin
        nrise++;
        if (rise_k < 0) rise_k = k;
      end
      if (busc.done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      prev_e = busc.lcd_e;
    end
    check("clr rise", rise_k, 2);
    check("clr strobes", nrise, 1);
    check("clr done_at", done_k, 76016);
    check("clr done_pulses", ndone, 1);
    check("clr db", busc.lcd_db, 8'h01);
  endtask

  // ---------------- main test ----------------
  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 1'b1, 8'h41, 1'b0, 1, 8'h41, 8'h41, 1866};
    vecs[1] = '{1, 1'b0, 8'h28, 1'b0, 2, 8'h20, 8'h80, 1882};
    vecs[2] = '{0, 1'b1, 8'h01, 1'b0, 1, 8'h01, 8'h01, 1866};
    vecs[3] = '{1, 1'b0, 8'h30, 1'b1, 1, 8'h30, 8'h30, 1866};
    vecs[4] = '{0, 1'b0, 8'h80, 1'b0, 1, 8'h80, 8'h80, 1866};
    vecs[5] = '{0, 1'b0, 8'h04, 1'b0, 1, 8'h04, 8'h04, 1866};
    vecs[6] = '{0, 1'b0, 8'h00, 1'b0, 1, 8'h00, 8'h00, 1866};
    vecs[7] = '{0, 1'b1, 8'h5A, 1'b1, 1, 8'h5A, 8'h5A, 1866};
    vecs[8] = '{1, 1'b1, 8'h02, 1'b0, 2, 8'h00, 8'h20, 1882};

    drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
    busc.req_valid = 1'b0; busc.req_rs = 1'b0; busc.req_data = 8'h00; busc.req_nibble = 1'b0;
    rst_m = 1'b0;
    rst_c = 1'b0;
    #2;
    rst_m = 1'b1;
    rst_c = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      snap_t s;
      s = snap(d);
      check($sformatf("reset%0d ready", d), s.ready, 1);
      check($sformatf("reset%0d e", d), s.e, 0);
      check($sformatf("reset%0d rs", d), s.rs, 0);
      check($sformatf("reset%0d db", d), s.db, 8'h00);
      check($sformatf("reset%0d done", d), s.done, 0);
      check($sformatf("reset%0d rw", d), s.rw, 0);
    end
    check("reset u8 state", bus8.dbg_state, 3'd0);
    repeat (3) @(negedge clk);
    rst_m = 1'b0;
    rst_c = 1'b0;

    fork
      clear_display();
      begin
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
        back_to_back();
        reset_mid_pulse();
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
